// File: rtl/hazard_detect_unit_pkg.sv
// ============================================================================
// Module      : hazard_detect_unit_pkg
// Description : Write-back source codes, register-address width default and
//               shadow-stage indices shared by the hazard detection unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HAZARD_DEFINES_VH
`define HAZARD_DEFINES_VH
`define WB_ALU  2'd0
`define WB_DRAM 2'd1
`define WB_PC4  2'd2
`define WB_IMM  2'd3
`define HAZARD_REG_AW 5
`endif

package hazard_detect_unit_pkg;

   localparam int         REG_AW_DEF   = `HAZARD_REG_AW;
   localparam logic [1:0] WB_CODE_ALU  = `WB_ALU;
   localparam logic [1:0] WB_CODE_DRAM = `WB_DRAM;
   localparam logic [1:0] WB_CODE_PC4  = `WB_PC4;
   localparam logic [1:0] WB_CODE_IMM  = `WB_IMM;

   typedef enum logic [1:0] {
      STG_EX  = 2'd0,
      STG_MEM = 2'd1,
      STG_WB  = 2'd2
   } stage_e;

   function automatic logic is_load(input logic [1:0] wsel);
      return (wsel == WB_CODE_DRAM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_dst_pipe.sv
// ============================================================================
// Module      : hazard_dst_pipe
// Description : Three-deep {we, wR, wsel} shadow of EX/MEM/WB with bubble insert.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_dst_pipe
   import hazard_detect_unit_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_we,
   input  logic [REG_AW-1:0]      in_wr,
   input  logic [1:0]             in_wsel,
   input  logic                   bubble,
   output logic [2:0]             st_we,
   output logic [2:0][REG_AW-1:0] st_wr,
   output logic [2:0][1:0]        st_wsel
);

   logic [2:0]             we_q,   we_d;
   logic [2:0][REG_AW-1:0] wr_q,   wr_d;
   logic [2:0][1:0]        wsel_q, wsel_d;

   always_comb begin
      we_d   = {we_q[STG_MEM],   we_q[STG_EX],   in_we & ~bubble};
      wr_d   = {wr_q[STG_MEM],   wr_q[STG_EX],   bubble ? {REG_AW{1'b0}} : in_wr};
      wsel_d = {wsel_q[STG_MEM], wsel_q[STG_EX], bubble ? 2'b00 : in_wsel};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= '0;
         wr_q   <= '0;
         wsel_q <= '0;
      end else begin
         we_q   <= we_d;
         wr_q   <= wr_d;
         wsel_q <= wsel_d;
      end
   end

   assign st_we   = we_q;
   assign st_wr   = wr_q;
   assign st_wsel = wsel_q;

endmodule

`default_nettype wire

// File: rtl/hazard_detect_unit.sv
// ============================================================================
// Module      : hazard_detect_unit
// Description : RAW flag generation against EX/MEM/WB shadow destinations,
//               load-use stall and branch flush control.
//               Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect_unit
   import hazard_detect_unit_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rR1,
   input  logic [REG_AW-1:0] id_rR2,
   input  logic              id_rR1_used,
   input  logic              id_rR2_used,
   input  logic [REG_AW-1:0] id_wR,
   input  logic              id_rf_we,
   input  logic [1:0]        id_rf_wsel,
   input  logic              ex_branch_taken,
   output logic              raw_a_rR1,
   output logic              raw_a_rR2,
   output logic              raw_b_rR1,
   output logic              raw_b_rR2,
   output logic              raw_c_rR1,
   output logic              raw_c_rR2,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   logic [2:0]             st_we;
   logic [2:0][REG_AW-1:0] st_wr;
   logic [2:0][1:0]        st_wsel;
   logic [2:0]             hit_r1, hit_r2;
   logic                   ex_is_load;
   logic                   load_use;
   logic                   unused_wsel;

   hazard_dst_pipe #(.REG_AW(REG_AW)) u_dst_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_we   (id_rf_we),
      .in_wr   (id_wR),
      .in_wsel (id_rf_wsel),
      .bubble  (flush_id_ex),
      .st_we   (st_we),
      .st_wr   (st_wr),
      .st_wsel (st_wsel)
   );

   // Only the EX stage needs its write-back source; MEM/WB hits forward regardless.
   assign unused_wsel = ^{st_wsel[STG_MEM], st_wsel[STG_WB]};

   always_comb begin
      hit_r1 = '0;
      hit_r2 = '0;
      for (int s = 0; s < 3; s++) begin
         hit_r1[s] = st_we[s] & (st_wr[s] != '0) & (st_wr[s] == id_rR1) & id_rR1_used;
         hit_r2[s] = st_we[s] & (st_wr[s] != '0) & (st_wr[s] == id_rR2) & id_rR2_used;
      end
      ex_is_load = is_load(st_wsel[STG_EX]);
      load_use   = (hit_r1[STG_EX] | hit_r2[STG_EX]) & ex_is_load;

      // rst_n gating keeps outputs quiet even though ex_branch_taken is unregistered.
      raw_a_rR1   = rst_n & hit_r1[STG_EX] & ~ex_is_load;
      raw_a_rR2   = rst_n & hit_r2[STG_EX] & ~ex_is_load;
      raw_b_rR1   = rst_n & hit_r1[STG_MEM];
      raw_b_rR2   = rst_n & hit_r2[STG_MEM];
      raw_c_rR1   = rst_n & hit_r1[STG_WB];
      raw_c_rR2   = rst_n & hit_r2[STG_WB];
      stall_pc    = rst_n & load_use & ~ex_branch_taken;
      stall_if_id = rst_n & load_use & ~ex_branch_taken;
      flush_if_id = rst_n & ex_branch_taken;
      flush_id_ex = rst_n & (ex_branch_taken | load_use);
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall_pc};
      flush_cnt_d = flush_cnt_q + {31'd0, flush_if_id};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = 32'd0;
   assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_detect_unit.sv
// ============================================================================
// Module      : tb_hazard_detect_unit
// Description : Directed scoreboard bench for hazard_detect_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_detect_unit;
   import hazard_detect_unit_pkg::*;

   localparam logic [9:0] A1  = 10'b1000000000;
   localparam logic [9:0] A2  = 10'b0100000000;
   localparam logic [9:0] B1  = 10'b0010000000;
   localparam logic [9:0] B2  = 10'b0001000000;
   localparam logic [9:0] C1  = 10'b0000100000;
   localparam logic [9:0] SPC = 10'b0000001000;
   localparam logic [9:0] SIF = 10'b0000000100;
   localparam logic [9:0] FIF = 10'b0000000010;
   localparam logic [9:0] FEX = 10'b0000000001;
   localparam logic [9:0] STALL = SPC | SIF | FEX;
   localparam logic [9:0] FLUSH = FIF | FEX;
   localparam logic [1:0] A = WB_CODE_ALU;
   localparam logic [1:0] D = WB_CODE_DRAM;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rR1, id_rR2, id_wR;
   logic        id_rR1_used, id_rR2_used, id_rf_we, ex_branch_taken;
   logic [1:0]  id_rf_wsel;
   logic        raw_a_rR1, raw_a_rR2, raw_b_rR1, raw_b_rR2, raw_c_rR1, raw_c_rR2;
   logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex;
   logic [31:0] stall_cnt, flush_cnt;

   typedef struct {
      logic [9:0]  vec;
      logic [31:0] scnt;
      logic [31:0] fcnt;
      int          id;
   } exp_t;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          step_no = 0;
   logic [31:0] acc_s = 0;
   logic [31:0] acc_f = 0;

   always #5 clk = ~clk;

   hazard_detect_unit #(.REG_AW(5)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rR1          (id_rR1),
      .id_rR2          (id_rR2),
      .id_rR1_used     (id_rR1_used),
      .id_rR2_used     (id_rR2_used),
      .id_wR           (id_wR),
      .id_rf_we        (id_rf_we),
      .id_rf_wsel      (id_rf_wsel),
      .ex_branch_taken (ex_branch_taken),
      .raw_a_rR1       (raw_a_rR1),
      .raw_a_rR2       (raw_a_rR2),
      .raw_b_rR1       (raw_b_rR1),
      .raw_b_rR2       (raw_b_rR2),
      .raw_c_rR1       (raw_c_rR1),
      .raw_c_rR2       (raw_c_rR2),
      .stall_pc        (stall_pc),
      .stall_if_id     (stall_if_id),
      .flush_if_id     (flush_if_id),
      .flush_id_ex     (flush_id_ex),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   // One ID-stage cycle: drive inputs, queue the expected flags and counters.
   task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic we,
                       input logic [4:0] wr, input logic [1:0] wsel,
                       input logic br, input logic [9:0] exp_vec);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n           = ~rst;
      id_rR1          = r1;
      id_rR2          = r2;
      id_rR1_used     = u1;
      id_rR2_used     = u2;
      id_rf_we        = we;
      id_wR           = wr;
      id_rf_wsel      = wsel;
      ex_branch_taken = br;
      if (rst) begin
         acc_s = 0;
         acc_f = 0;
      end
      e.vec = exp_vec;
      e.id  = step_no;
`ifdef HAZARD_PERF_CNT_EN
      e.scnt = acc_s;
      e.fcnt = acc_f;
`else
      e.scnt = 32'd0;
      e.fcnt = 32'd0;
`endif
      sb_q.push_back(e);
      if (!rst) begin
         acc_s = acc_s + {31'd0, exp_vec[3]};
         acc_f = acc_f + {31'd0, exp_vec[1]};
      end
      step_no++;
   endtask

   initial begin : monitor
      exp_t        e;
      logic [9:0]  act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {raw_a_rR1, raw_a_rR2, raw_b_rR1, raw_b_rR2, raw_c_rR1, raw_c_rR2,
                   stall_pc, stall_if_id, flush_if_id, flush_id_ex};
            checks++;
            if (act !== e.vec) begin
               errors++;
               $display("FAIL step%0d flags: got %b want %b (a1a2b1b2c1c2 spc sif fif fex)",
                        e.id, act, e.vec);
            end
            checks++;
            if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
               errors++;
               $display("FAIL step%0d counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                        e.id, stall_cnt, flush_cnt, e.scnt, e.fcnt);
            end
         end
      end
   end

   initial begin : driver
      rst_n = 1'b0;
      id_rR1 = '0; id_rR2 = '0; id_wR = '0;
      id_rR1_used = 1'b0; id_rR2_used = 1'b0;
      id_rf_we = 1'b0; id_rf_wsel = A; ex_branch_taken = 1'b0;

      // reset with a branch pending: everything reads 0
      step(1, 0, 0, 0, 0, 0, 0, A, 1, 0);
      step(1, 5, 5, 1, 1, 1, 5, A, 1, 0);
      // ALU producer x5 walks EX -> MEM -> WB
      step(0, 0, 0, 0, 0, 1, 5, A, 0, 0);
      step(0, 5, 0, 1, 0, 0, 0, A, 0, A1);
      step(0, 5, 0, 1, 0, 0, 0, A, 0, B1);
      step(0, 5, 0, 1, 0, 0, 0, A, 0, C1);
      step(0, 5, 0, 1, 0, 0, 0, A, 0, 0);
      // load-use on rR2
      step(0, 0, 0, 0, 0, 1, 6, D, 0, 0);
      step(0, 0, 6, 0, 1, 1, 10, A, 0, STALL);
      step(0, 0, 6, 0, 1, 1, 10, A, 0, B2);
      step(0, 0, 0, 0, 0, 0, 0, A, 0, 0);
      // x0 writer never hazards
      step(0, 0, 0, 1, 1, 1, 0, A, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0, A, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0, A, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0, A, 0, 0);
      // load-use coinciding with a branch: flush only, EX becomes bubble
      step(0, 0, 0, 0, 0, 1, 7, D, 0, 0);
      step(0, 7, 0, 1, 0, 1, 11, A, 1, FLUSH);
      step(0, 7, 11, 1, 1, 0, 0, A, 0, B1);
      // same destination x9 in EX and MEM
      step(0, 0, 0, 0, 0, 1, 9, A, 0, 0);
      step(0, 0, 0, 0, 0, 1, 9, A, 0, 0);
      step(0, 9, 9, 1, 1, 0, 0, A, 0, A1 | A2 | B1 | B2);
      step(0, 9, 9, 1, 0, 0, 0, A, 0, B1 | C1);
      // two more load-use stalls and one more branch
      step(0, 0, 0, 0, 0, 1, 8, D, 0, 0);
      step(0, 8, 0, 1, 0, 0, 0, A, 0, STALL);
      step(0, 8, 0, 1, 0, 0, 0, A, 0, B1);
      step(0, 0, 0, 0, 0, 1, 12, D, 0, 0);
      step(0, 0, 12, 0, 1, 1, 13, D, 0, STALL);
      step(0, 0, 12, 0, 1, 1, 13, D, 0, B2);
      step(0, 0, 0, 0, 0, 0, 0, A, 1, FLUSH);
      step(0, 0, 0, 0, 0, 0, 0, A, 0, 0);
      // reset in the middle of a stall
      step(0, 0, 0, 0, 0, 1, 14, D, 0, 0);
      step(0, 14, 0, 1, 0, 0, 0, A, 0, STALL);
      step(1, 14, 0, 1, 0, 0, 0, A, 0, 0);
      step(0, 14, 0, 1, 0, 0, 0, A, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, A, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
